// File: rtl/qdiv_arb_pkg.sv
// -----------------------------------------------------------------------------
// qdiv_arb_pkg
// Shared definitions for the Q16.16 divider-sharing arbiter: FSM state
// encoding, fixed-point constants, default requester count and watchdog width.
// No ports (package).
// -----------------------------------------------------------------------------
package qdiv_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_LOW  = 2'd1,
        ST_WAIT_HIGH = 2'd2,
        ST_DONE      = 2'd3
    } arb_state_t;

    localparam logic [31:0] Q_ONE    = 32'h0001_0000;
    localparam logic [31:0] Q_SAT    = 32'hFFFF_FFFF;
    localparam int          NREQ_DEF = 4;

    // Wide enough for the largest supported TIMEOUT_CYC (65535).
    localparam int          WDOG_W   = 16;

endpackage

// File: rtl/qdiv_share_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. The search starts at (last + 1) mod NREQ
// and wraps, so the previously served requester has the lowest priority.
//
// Ports:
//   req      in   NREQ  request vector
//   last     in   IW    index of the last granted requester
//   winner   out  IW    selected requester (don't-care when any_req = 0)
//   any_req  out  1     at least one request bit is set
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [IW-1:0]   winner,
    output logic            any_req
);

    always_comb begin
        winner  = '0;
        any_req = |req;
        // Pass 1: lowest set bit overall. This is the wrapped-around choice.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner = IW'(i);
            end
        end
        // Pass 2: lowest set bit strictly above last. When one exists it
        // overrides the wrapped choice.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i] && (i > int'(last))) begin
                winner = IW'(i);
            end
        end
    end

endmodule

// File: rtl/qdiv_share_arb.sv
// -----------------------------------------------------------------------------
// qdiv_share_arb
// Round-robin arbiter that shares one Q16.16 divider between NREQ requesters.
// It registers the winner's operands toward the divider. It then waits for the
// divider's valid to go low, and then for a fresh 0->1 edge, so a result left
// over from the previous operand set is never taken. The quotient is returned
// with a one-cycle ack.
//
// Optional feature: define QDIV_ARB_TIMEOUT_EN to enable a watchdog. After
// TIMEOUT_CYC clocks in the wait states, the operation completes with err = 1
// and result = Q_SAT.
//
// Ports:
//   clk          in   1        clock, rising edge
//   rst_n        in   1        asynchronous active-low reset
//   req          in   NREQ     request levels, held until ack
//   op_a, op_b   in   32*NREQ  packed Q16.16 dividends / divisors
//   ack          out  NREQ     one-cycle completion pulse (one-hot)
//   result       out  32       quotient, nonzero only in the ack cycle
//   err          out  1        timeout flag, only with ack
//   busy         out  1        FSM not in IDLE
//   grant_id     out  clog2    requester being served (holds in IDLE)
//   unit_a/b     out  32       registered operands to the shared divider
//   unit_valid   in   1        divider result valid level
//   unit_result  in   32       divider quotient
//
// state      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | no operation; arbitrate among pending requests
// WAIT_LOW   | operands issued; wait for the divider's valid to drop
// WAIT_HIGH  | wait for a 0->1 edge of valid; capture the quotient
// DONE       | single ack cycle for the granted requester
// -----------------------------------------------------------------------------
module qdiv_share_arb
    import qdiv_arb_pkg::*;
#(
    parameter int NREQ        = NREQ_DEF,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req,
    input  logic [32*NREQ-1:0]        op_a,
    input  logic [32*NREQ-1:0]        op_b,
    output logic [NREQ-1:0]           ack,
    output logic [31:0]               result,
    output logic                      err,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic [31:0]               unit_a,
    output logic [31:0]               unit_b,
    input  logic                      unit_valid,
    input  logic [31:0]               unit_result
);

    localparam int GW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("qdiv_share_arb: NREQ must be 2..8");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("qdiv_share_arb: TIMEOUT_CYC must be 1..65535");
    end

    arb_state_t         r_state;
    arb_state_t         w_next;
    logic [GW-1:0]      r_last;
    logic [GW-1:0]      r_grant_id;
    logic               r_valid_q;
    logic [31:0]        r_unit_a;
    logic [31:0]        r_unit_b;
    logic [NREQ-1:0]    r_ack;
    logic [31:0]        r_result;

    logic [GW-1:0]      w_winner;
    logic               w_any_req;
    logic               w_grant;
    logic               w_done_ok;
    logic               w_done_to;
    logic               w_wdog_hit;
    logic [31:0]        w_sel_a;
    logic [31:0]        w_sel_b;
    logic [NREQ-1:0]    w_ack_onehot;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (GW)
    ) u_rr_pick (
        .req     (req),
        .last    (r_last),
        .winner  (w_winner),
        .any_req (w_any_req)
    );

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_winner == GW'(i)) begin
                w_sel_a = op_a[32*i +: 32];
                w_sel_b = op_b[32*i +: 32];
            end
        end
    end

    assign w_ack_onehot = NREQ'(1) << r_grant_id;

`ifdef QDIV_ARB_TIMEOUT_EN
    logic [WDOG_W-1:0] r_wdog;
    logic              r_err;

    // The counter reads k-1 in the k-th wait cycle after the grant. Hitting
    // TIMEOUT_CYC-1 therefore puts DONE exactly TIMEOUT_CYC edges after the
    // grant.
    assign w_wdog_hit = (r_wdog == WDOG_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_grant) begin
                r_wdog <= '0;
            end else if (r_state == ST_WAIT_LOW || r_state == ST_WAIT_HIGH) begin
                r_wdog <= r_wdog + 1'b1;
            end
            r_err <= w_done_to;
        end
    end

    assign err = r_err;
`else
    assign w_wdog_hit = 1'b0;
    assign err        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A genuine valid edge takes priority over a watchdog hit in the same
    // cycle, so a real quotient is never discarded.
    always_comb begin
        w_next    = r_state;
        w_grant   = 1'b0;
        w_done_ok = 1'b0;
        w_done_to = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_grant = 1'b1;
                    w_next  = ST_WAIT_LOW;
                end
            end
            ST_WAIT_LOW: begin
                if (w_wdog_hit) begin
                    w_done_to = 1'b1;
                    w_next    = ST_DONE;
                end else if (!unit_valid) begin
                    w_next = ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
                if (unit_valid && !r_valid_q) begin
                    w_done_ok = 1'b1;
                    w_next    = ST_DONE;
                end else if (w_wdog_hit) begin
                    w_done_to = 1'b1;
                    w_next    = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // ack and result are registered on the transition into DONE and cleared
    // on every other edge, so both are zero outside the ack cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last     <= GW'(NREQ - 1);
            r_grant_id <= '0;
            r_valid_q  <= 1'b0;
            r_unit_a   <= '0;
            r_unit_b   <= '0;
            r_ack      <= '0;
            r_result   <= '0;
        end else begin
            r_valid_q <= unit_valid;
            r_ack     <= '0;
            r_result  <= '0;
            if (w_grant) begin
                r_unit_a   <= w_sel_a;
                r_unit_b   <= w_sel_b;
                r_grant_id <= w_winner;
                r_last     <= w_winner;
            end
            if (w_done_ok) begin
                r_ack    <= w_ack_onehot;
                r_result <= unit_result;
            end else if (w_done_to) begin
                r_ack    <= w_ack_onehot;
                r_result <= Q_SAT;
            end
        end
    end

    assign ack      = r_ack;
    assign result   = r_result;
    assign busy     = (r_state != ST_IDLE);
    assign grant_id = r_grant_id;
    assign unit_a   = r_unit_a;
    assign unit_b   = r_unit_b;

endmodule

// File: tb/tb_qdiv_share_arb.sv
module tb_qdiv_share_arb;

    localparam int NREQ = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [3:0]     req;
    logic [127:0]   op_a;
    logic [127:0]   op_b;
    logic [3:0]     ack;
    logic [31:0]    result;
    logic           err;
    logic           busy;
    logic [1:0]     grant_id;
    logic [31:0]    unit_a;
    logic [31:0]    unit_b;
    logic           unit_valid;
    logic [31:0]    unit_result;

    int n_cmp = 0;
    int n_mis = 0;
    int n;
    int exp_id;
    logic seen;

    always #5 clk = ~clk;

    qdiv_share_arb #(
        .NREQ        (NREQ),
        .TIMEOUT_CYC (10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .op_a        (op_a),
        .op_b        (op_b),
        .ack         (ack),
        .result      (result),
        .err         (err),
        .busy        (busy),
        .grant_id    (grant_id),
        .unit_a      (unit_a),
        .unit_b      (unit_b),
        .unit_valid  (unit_valid),
        .unit_result (unit_result)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one step after the grant edge. The divider drops valid for one
    // cycle, then raises it with res, so ack appears on the second edge.
    task automatic finish_op(input logic [31:0] res);
        unit_valid = 1'b0;
        tick();
        unit_valid  = 1'b1;
        unit_result = res;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        req         = '0;
        op_a        = '0;
        op_b        = '0;
        unit_valid  = 1'b0;
        unit_result = '0;
        repeat (3) tick();

        chk("rst_ack",    ack,      0);
        chk("rst_result", result,   0);
        chk("rst_err",    err,      0);
        chk("rst_busy",   busy,     0);
        chk("rst_gid",    grant_id, 0);
        chk("rst_ua",     unit_a,   0);
        chk("rst_ub",     unit_b,   0);
        rst_n = 1'b1;

        // Single request: 3.0 / 2.0 = 1.5
        op_a[31:0]  = 32'h0003_0000;
        op_b[31:0]  = 32'h0002_0000;
        unit_valid  = 1'b1;
        req         = 4'b0001;
        tick();
        chk("s_busy", busy,     1);
        chk("s_gid",  grant_id, 0);
        chk("s_ua",   unit_a,   32'h0003_0000);
        chk("s_ub",   unit_b,   32'h0002_0000);
        chk("s_ack0", ack,      0);
        unit_valid = 1'b0;
        tick();
        chk("s_ack1", ack, 0);
        unit_valid  = 1'b1;
        unit_result = 32'h0001_8000;
        tick();
        chk("s_ack",    ack,    4'b0001);
        chk("s_result", result, 32'h0001_8000);
        chk("s_err",    err,    0);
        req = 4'b0000;
        tick();
        chk("s_ack_after", ack,    0);
        chk("s_res_after", result, 0);
        chk("s_idle",      busy,   0);

        // Contention from a fresh reset: order 0,1,2,3,0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            op_a[32*i +: 32] = (i + 1) << 16;
            op_b[32*i +: 32] = 32'h0001_0000;
        end
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_id = k % 4;
            n = 0;
            do begin
                tick();
                n++;
            end while (!busy && n < 8);
            chk("c_busy", busy,     1);
            chk("c_gid",  grant_id, exp_id);
            chk("c_ua",   unit_a,   (exp_id + 1) << 16);
            finish_op((exp_id + 1) << 16);
            chk("c_ack",    ack,    1 << exp_id);
            chk("c_result", result, (exp_id + 1) << 16);
            if (k == 4) req = 4'b0000;
        end
        tick();
        tick();
        chk("c_idle", busy, 0);

        // Stale valid held high across the grant edge
        unit_valid  = 1'b1;
        unit_result = 32'hDEAD_BEEF;
        req         = 4'b0010;
        tick();
        chk("v_busy", busy,     1);
        chk("v_gid",  grant_id, 1);
        tick();
        chk("v_ack_hi", ack, 0);
        unit_valid = 1'b0;
        tick();
        chk("v_ack_lo1", ack, 0);
        tick();
        chk("v_ack_lo2", ack, 0);
        unit_valid  = 1'b1;
        unit_result = 32'h0000_4000;
        tick();
        chk("v_ack",    ack,    4'b0010);
        chk("v_result", result, 32'h0000_4000);
        req = 4'b0000;
        tick();

        // Requester 1 drops req mid-operation; operands toggle after grant
        op_a[63:32] = 32'h0005_0000;
        op_b[63:32] = 32'h0004_0000;
        req         = 4'b0010;
        tick();
        chk("d_gid", grant_id, 1);
        op_a[63:32] = 32'h1234_5678;
        op_b[63:32] = 32'h9ABC_DEF0;
        unit_valid  = 1'b0;
        tick();
        req         = 4'b0000;
        op_a[63:32] = 32'h0BAD_0BAD;
        op_b[63:32] = 32'h0F0F_0F0F;
        tick();
        chk("d_busy", busy,   1);
        chk("d_ua",   unit_a, 32'h0005_0000);
        chk("d_ub",   unit_b, 32'h0004_0000);
        chk("d_ack0", ack,    0);
        unit_valid  = 1'b1;
        unit_result = 32'h0001_4000;
        tick();
        chk("d_ack",    ack,    4'b0010);
        chk("d_result", result, 32'h0001_4000);
        tick();
        chk("d_ack_after", ack,  0);
        chk("d_idle",      busy, 0);

        // Divider stuck low
        unit_valid = 1'b0;
        req        = 4'b0001;
        tick();
        chk("t_gid", grant_id, 0);
        n    = 0;
        seen = 1'b0;
        while (n < 30 && !seen) begin
            tick();
            n++;
            if (ack != 4'b0000) seen = 1'b1;
        end
`ifdef QDIV_ARB_TIMEOUT_EN
        chk("t_cycles", n,      10);
        chk("t_ack",    ack,    4'b0001);
        chk("t_err",    err,    1);
        chk("t_result", result, 32'hFFFF_FFFF);
        req = 4'b0000;
        tick();
        chk("t_err_after", err,    0);
        chk("t_res_after", result, 0);
`else
        chk("t_no_ack", seen, 0);
        chk("t_busy",   busy, 1);
        chk("t_err",    err,  0);
        unit_valid  = 1'b1;
        unit_result = 32'h0001_0000;
        tick();
        chk("t_late_ack", ack,    4'b0001);
        chk("t_late_res", result, 32'h0001_0000);
        req = 4'b0000;
        tick();
`endif
        tick();
        chk("t_idle", busy, 0);

        // Reset asserted in WAIT_HIGH
        unit_valid = 1'b0;
        req        = 4'b1000;
        tick();
        chk("r_gid", grant_id, 3);
        tick();
        chk("r_busy_pre", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_busy",   busy,     0);
        chk("r_ack",    ack,      0);
        chk("r_result", result,   0);
        chk("r_err",    err,      0);
        chk("r_ua",     unit_a,   0);
        chk("r_ub",     unit_b,   0);
        chk("r_gid0",   grant_id, 0);
        req = 4'b0100;
        tick();
        chk("r_ack_held", ack, 0);
        rst_n = 1'b1;
        tick();
        chk("r2_busy", busy,     1);
        chk("r2_gid",  grant_id, 2);
        chk("r2_ua",   unit_a,   32'h0003_0000);
        finish_op(32'h0003_0000);
        chk("r2_ack",    ack,    4'b0100);
        chk("r2_result", result, 32'h0003_0000);
        req = 4'b0000;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
